// File: rtl/dta_ingr_rcv_req_scheduler.sv
// Round-robin scheduler that shares one ingress receive req/resp/data channel set
// between NUM_SRC requesters, keeping exactly one transaction outstanding.
module dta_ingr_rcv_req_scheduler #(
  parameter int          NUM_SRC       = 4,
  parameter logic [15:0] MAX_BURST_LEN = 16'd64
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [NUM_SRC-1:0]      src_req_valid,
  output logic [NUM_SRC-1:0]      src_req_ready,
  input  logic [64*NUM_SRC-1:0]   src_req_data,
  output logic                    req_tvalid,
  input  logic                    req_tready,
  output logic [63:0]             req_tdata,
  input  logic                    resp_tvalid,
  output logic                    resp_tready,
  input  logic [63:0]             resp_tdata,
  input  logic                    data_tvalid,
  output logic                    data_tready,
  input  logic [511:0]            data_tdata,
  output logic                    m_data_tvalid,
  input  logic                    m_data_tready,
  output logic [511:0]            m_data_tdata,
  output logic [2:0]              m_data_tdest,
  output logic                    m_data_tlast,
  output logic                    err_reject,
  output logic                    err_resp,
  output logic                    busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_RESP  = 3'd3,
    ST_DATA  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [2:0]           win_q, win_d;
  logic [63:0]          req_word_q, req_word_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [NUM_SRC-1:0]   src_ready_q, src_ready_d;
  logic                 err_reject_q, err_reject_d;
  logic                 err_resp_q, err_resp_d;

  logic [7:0]           valid_pad_s;
  logic [511:0]         data_pad_s;
  logic                 found_s;
  logic [2:0]           pick_s;
  logic [7:0]           onehot_s;
  logic [63:0]          pick_word_s;
  logic [15:0]          req_len_s;
  logic [15:0]          resp_len_s;
  logic                 resp_mismatch_s;
  logic                 unused_resp_bits_s;

  assign valid_pad_s = 8'(src_req_valid);
  assign data_pad_s  = 512'(src_req_data);
  assign onehot_s    = 8'd1 << pick_s;
  assign pick_word_s = data_pad_s[{pick_s, 6'd0} +: 64];
  assign req_len_s   = req_word_q[63:48];
  assign resp_len_s  = resp_tdata[63:48];
  assign resp_mismatch_s = (resp_tdata[15:0] != req_word_q[15:0]) ||
                           (resp_tdata[32]   != req_word_q[32])   ||
                           (resp_tdata[33]   != req_word_q[33])   ||
                           (resp_len_s       >  req_len_s);
  assign unused_resp_bits_s = ^{resp_tdata[47:34], resp_tdata[31:16]};

  // Round-robin search: first valid source at or after the pointer, wrapping at NUM_SRC.
  always_comb begin
    logic [3:0] idx;
    found_s = 1'b0;
    pick_s  = 3'd0;
    idx     = 4'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(NUM_SRC)) begin
        idx = idx - 4'(NUM_SRC);
      end else begin
        idx = idx;
      end
      if (!found_s && valid_pad_s[idx[2:0]]) begin
        found_s = 1'b1;
        pick_s  = idx[2:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-register logic of the transaction FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    req_word_d   = req_word_q;
    cnt_d        = cnt_q;
    src_ready_d  = '0;
    err_reject_d = 1'b0;
    err_resp_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          src_ready_d = onehot_s[NUM_SRC-1:0];
          req_word_d  = pick_word_s;
          win_d       = pick_s;
          ptr_d       = (pick_s == 3'(NUM_SRC - 1)) ? 3'd0 : pick_s + 3'd1;
          state_d     = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // The granted word is validated one cycle after it is latched.
      ST_CHECK: begin
        if ((req_len_s == 16'd0) || (req_len_s > MAX_BURST_LEN)) begin
          err_reject_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (req_tready) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        if (resp_tvalid) begin
          err_resp_d = resp_mismatch_s;
          if (resp_len_s == 16'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = resp_len_s;
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_DATA: begin
        if (data_tvalid && m_data_tready) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 3'd0;
      win_q        <= 3'd0;
      req_word_q   <= 64'd0;
      cnt_q        <= 16'd0;
      src_ready_q  <= '0;
      err_reject_q <= 1'b0;
      err_resp_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      req_word_q   <= req_word_d;
      cnt_q        <= cnt_d;
      src_ready_q  <= src_ready_d;
      err_reject_q <= err_reject_d;
      err_resp_q   <= err_resp_d;
    end
  end

  assign src_req_ready = src_ready_q;
  assign req_tvalid    = (state_q == ST_REQ);
  assign req_tdata     = req_word_q;
  assign resp_tready   = (state_q == ST_RESP);
  // Data path is a pure pass-through while a burst is granted.
  assign data_tready   = (state_q == ST_DATA) && m_data_tready;
  assign m_data_tvalid = (state_q == ST_DATA) && data_tvalid;
  assign m_data_tdata  = data_tdata;
  assign m_data_tdest  = win_q;
  assign m_data_tlast  = (state_q == ST_DATA) && (cnt_q == 16'd1);
  assign err_reject    = err_reject_q;
  assign err_resp      = err_resp_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dta_ingr_rcv_req_scheduler.sv
// Directed bench for the ingress receive request scheduler; expected values are
// hand-computed from the request/response words the bench itself drives.
module tb_dta_ingr_rcv_req_scheduler;

  logic           ap_clk = 1'b0;
  logic           ap_rst_n;
  logic [3:0]     src_req_valid;
  logic [3:0]     src_req_ready;
  logic [255:0]   src_req_data;
  logic           req_tvalid, req_tready;
  logic [63:0]    req_tdata;
  logic           resp_tvalid, resp_tready;
  logic [63:0]    resp_tdata;
  logic           data_tvalid, data_tready;
  logic [511:0]   data_tdata;
  logic           m_data_tvalid, m_data_tready;
  logic [511:0]   m_data_tdata;
  logic [2:0]     m_data_tdest;
  logic           m_data_tlast;
  logic           err_reject, err_resp, busy;

  int n_chk  = 0;
  int n_fail = 0;

  dta_ingr_rcv_req_scheduler #(.NUM_SRC(4), .MAX_BURST_LEN(16'd64)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .src_req_valid(src_req_valid), .src_req_ready(src_req_ready), .src_req_data(src_req_data),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .resp_tvalid(resp_tvalid), .resp_tready(resp_tready), .resp_tdata(resp_tdata),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
    .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready), .m_data_tdata(m_data_tdata),
    .m_data_tdest(m_data_tdest), .m_data_tlast(m_data_tlast),
    .err_reject(err_reject), .err_resp(err_resp), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge ap_clk);
  endtask

  function automatic logic [63:0] mk(input logic [15:0] len, input logic eof,
                                     input logic sof, input logic [15:0] ch);
    return {len, 14'd0, eof, sof, 16'hBEEF, ch};
  endfunction

  function automatic logic [511:0] beat(input int b);
    return {8{64'hC0DE_0000_0000_0000 | 64'(b)}};
  endfunction

  task automatic set_word(input int s, input logic [63:0] w);
    src_req_data[64*s +: 64] = w;
  endtask

  task automatic do_reset();
    tick();
    ap_rst_n = 1'b0;
    src_req_valid = 4'd0; req_tready = 1'b0; resp_tvalid = 1'b0;
    data_tvalid = 1'b0; m_data_tready = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_tvalid", req_tvalid, 1'b0);
    chk("rst_req_tdata", req_tdata, 64'd0);
    chk("rst_src_ready", src_req_ready, 4'd0);
    chk("rst_tdest", m_data_tdest, 3'd0);
    chk("rst_errs", {err_reject, err_resp, resp_tready, data_tready, m_data_tvalid}, 5'd0);
    tick();
    ap_rst_n = 1'b1;
  endtask

  // Starts at a negedge in IDLE with valids already driven; returns at the negedge
  // right after the resp handshake (first DATA cycle, or IDLE for a zero-length resp).
  task automatic txn(input int src, input logic [63:0] word, input logic [63:0] rword,
                     input logic drop, input logic exp_err);
    tick(); #1;
    chk("grant_ready", src_req_ready, 4'd1 << src);
    chk("grant_busy", busy, 1'b1);
    chk("grant_no_req", req_tvalid, 1'b0);
    if (drop) src_req_valid[src] = 1'b0;
    tick(); #1;
    chk("req_tvalid", req_tvalid, 1'b1);
    chk("req_tdata", req_tdata, word);
    chk("req_ready_low", src_req_ready, 4'd0);
    req_tready = 1'b1;
    tick();
    req_tready = 1'b0;
    #1;
    chk("resp_tready", resp_tready, 1'b1);
    chk("req_tvalid_low", req_tvalid, 1'b0);
    resp_tvalid = 1'b1;
    resp_tdata  = rword;
    tick();
    resp_tvalid = 1'b0;
    #1;
    chk("err_resp", err_resp, exp_err);
    chk("resp_tready_low", resp_tready, 1'b0);
  endtask

  task automatic beats(input int n, input int src);
    for (int b = 1; b <= n; b++) begin
      data_tvalid = 1'b1; m_data_tready = 1'b1; data_tdata = beat(b);
      #1;
      chk("m_tvalid", m_data_tvalid, 1'b1);
      chk("data_tready", data_tready, 1'b1);
      chk("m_tdata", m_data_tdata, beat(b));
      chk("m_tdest", m_data_tdest, 3'(src));
      chk("m_tlast", m_data_tlast, (b == n));
      tick();
    end
    #1;
    chk("post_busy", busy, 1'b0);
    chk("post_stall", data_tready, 1'b0);
    chk("post_m_tvalid", m_data_tvalid, 1'b0);
    data_tvalid = 1'b0; m_data_tready = 1'b0;
  endtask

  initial begin
    ap_rst_n = 1'b0;
    src_req_valid = 4'd0; src_req_data = '0;
    req_tready = 1'b0; resp_tvalid = 1'b0; resp_tdata = 64'd0;
    data_tvalid = 1'b0; data_tready_dummy: begin end
    data_tdata = '0; m_data_tready = 1'b0;
    do_reset();

    // Single request from src1, echoed resp, four beats.
    set_word(1, mk(16'd4, 1'b1, 1'b1, 16'd7));
    src_req_valid = 4'b0010;
    txn(1, mk(16'd4, 1'b1, 1'b1, 16'd7), mk(16'd4, 1'b1, 1'b1, 16'd7), 1'b1, 1'b0);
    beats(4, 1);

    // All sources valid continuously, single-beat bursts: grants rotate 0,1,2,3,0,1.
    do_reset();
    for (int s = 0; s < 4; s++) set_word(s, mk(16'd1, 1'b0, 1'b0, 16'(s + 16)));
    src_req_valid = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      txn(t % 4, mk(16'd1, 1'b0, 1'b0, 16'((t % 4) + 16)),
          mk(16'd1, 1'b0, 1'b0, 16'((t % 4) + 16)), 1'b0, 1'b0);
      if (t == 5) src_req_valid = 4'd0;
      beats(1, t % 4);
    end

    // Zero-length and oversize requests are rejected; pointer wraps back to 0.
    do_reset();
    set_word(2, mk(16'd0, 1'b0, 1'b0, 16'd2));
    set_word(3, mk(16'd65, 1'b0, 1'b0, 16'd3));
    src_req_valid = 4'b0100;
    tick(); #1;
    chk("rej2_ready", src_req_ready, 4'b0100);
    src_req_valid = 4'b0000;
    tick(); #1;
    chk("rej2_pulse", err_reject, 1'b1);
    chk("rej2_no_req", req_tvalid, 1'b0);
    chk("rej2_idle", busy, 1'b0);
    src_req_valid = 4'b1000;
    tick(); #1;
    chk("rej3_ready", src_req_ready, 4'b1000);
    chk("rej_pulse_1cyc", err_reject, 1'b0);
    src_req_valid = 4'b0000;
    tick(); #1;
    chk("rej3_pulse", err_reject, 1'b1);
    chk("rej3_no_req", req_tvalid, 1'b0);
    set_word(0, mk(16'd1, 1'b0, 1'b0, 16'd0));
    set_word(1, mk(16'd1, 1'b0, 1'b0, 16'd1));
    src_req_valid = 4'b1011;
    txn(0, mk(16'd1, 1'b0, 1'b0, 16'd0), mk(16'd1, 1'b0, 1'b0, 16'd0), 1'b0, 1'b0);
    src_req_valid = 4'd0;
    beats(1, 0);

    // Short resp is legal; then a channel mismatch flags err_resp but still runs data.
    set_word(0, mk(16'd8, 1'b1, 1'b0, 16'd5));
    src_req_valid = 4'b0001;
    txn(0, mk(16'd8, 1'b1, 1'b0, 16'd5), mk(16'd3, 1'b1, 1'b0, 16'd5), 1'b1, 1'b0);
    beats(3, 0);
    set_word(0, mk(16'd2, 1'b0, 1'b1, 16'd9));
    src_req_valid = 4'b0001;
    txn(0, mk(16'd2, 1'b0, 1'b1, 16'd9), mk(16'd2, 1'b0, 1'b1, 16'd10), 1'b1, 1'b1);
    beats(2, 0);
    #1;
    chk("err_resp_1cyc", err_resp, 1'b0);

    // Zero-length resp returns to IDLE without a data phase; next grant proceeds.
    set_word(1, mk(16'd4, 1'b0, 1'b0, 16'd3));
    set_word(2, mk(16'd1, 1'b0, 1'b0, 16'd4));
    src_req_valid = 4'b0010;
    txn(1, mk(16'd4, 1'b0, 1'b0, 16'd3), mk(16'd0, 1'b0, 1'b0, 16'd3), 1'b1, 1'b0);
    data_tvalid = 1'b1; m_data_tready = 1'b1;
    #1;
    chk("zl_no_data", data_tready, 1'b0);
    chk("zl_idle", busy, 1'b0);
    data_tvalid = 1'b0; m_data_tready = 1'b0;
    src_req_valid = 4'b0100;
    txn(2, mk(16'd1, 1'b0, 1'b0, 16'd4), mk(16'd1, 1'b0, 1'b0, 16'd4), 1'b1, 1'b0);
    beats(1, 2);

    // Backpressure toggling in DATA, then reset mid-burst after beat 2 of 4.
    do_reset();
    set_word(0, mk(16'd4, 1'b0, 1'b0, 16'd1));
    src_req_valid = 4'b0001;
    txn(0, mk(16'd4, 1'b0, 1'b0, 16'd1), mk(16'd4, 1'b0, 1'b0, 16'd1), 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      data_tvalid = 1'b1;
      m_data_tready = (c % 2 == 0);
      data_tdata = beat(c / 2 + 1);
      #1;
      chk("bp_m_tvalid", m_data_tvalid, 1'b1);
      chk("bp_data_tready", data_tready, (c % 2 == 0));
      chk("bp_tlast", m_data_tlast, 1'b0);
      tick();
    end
    data_tvalid = 1'b1; m_data_tready = 1'b1;
    #1;
    chk("mid_busy", busy, 1'b1);
    ap_rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_m_tvalid", m_data_tvalid, 1'b0);
    chk("arst_data_tready", data_tready, 1'b0);
    chk("arst_tdest_tdata", {m_data_tdest, req_tdata}, 67'd0);
    chk("arst_valids", {req_tvalid, resp_tready, src_req_ready}, 6'd0);
    data_tvalid = 1'b0; m_data_tready = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    set_word(1, mk(16'd1, 1'b0, 1'b0, 16'd1));
    src_req_valid = 4'b0011;
    tick(); #1;
    chk("post_rst_ptr0", src_req_ready, 4'b0001);
    src_req_valid = 4'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
